// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Holds the frame receiver state encoding, the scan-code prefix bytes,
// the default key-code map and a parity helper.
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  // Default key map: A, S, D, F
  localparam logic [7:0] DEF_KEY0_CODE = 8'h1C;
  localparam logic [7:0] DEF_KEY1_CODE = 8'h1B;
  localparam logic [7:0] DEF_KEY2_CODE = 8'h23;
  localparam logic [7:0] DEF_KEY3_CODE = 8'h2B;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver.
// Synchronises the raw keyboard clock/data, detects falling clock edges, and
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
// A partial frame is silently dropped after TimeoutCycles clocks with no edge.
// Ports:
//   clk_i, rst_ni    system clock, async active-low reset
//   ps2_clk_i        raw PS/2 clock (asynchronous)
//   ps2_dat_i        raw PS/2 data (asynchronous)
//   scan_code_o      last correctly received byte
//   scan_valid_o     one-cycle strobe, scan_code_o is new
//   frame_error_o    one-cycle strobe on start/parity/stop violation
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       frame_error_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  // Synchronisers reset to the idle-high bus level so reset never fakes an edge
  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (state_q == StIdle || fall) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // An edge always wins over a coinciding timeout
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        StData: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
            code_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && cnt_q == CntMax) begin
      state_d = StIdle;
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign scan_code_o   = code_q;
  assign scan_valid_o  = valid_q;
  assign frame_error_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard key decoder.
// Receives keyboard frames and tracks make/break codes for four mapped keys,
// producing a held-key vector usable in place of SW[3:0].
// Ports:
//   clock        system clock
//   reset        async active-low reset
//   ps2_clk      raw PS/2 clock
//   ps2_dat      raw PS/2 data
//   keys         held-key vector, bit n set while KEYn_CODE is down
//   scan_code    last correctly received byte
//   scan_valid   one-cycle strobe, scan_code is new
//   frame_error  one-cycle strobe on a framing/parity violation
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  KEY0_CODE      = DEF_KEY0_CODE,
  parameter logic [7:0]  KEY1_CODE      = DEF_KEY1_CODE,
  parameter logic [7:0]  KEY2_CODE      = DEF_KEY2_CODE,
  parameter logic [7:0]  KEY3_CODE      = DEF_KEY3_CODE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam logic [3:0][7:0] KeyCodes = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

  logic [3:0] keys_q, keys_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;

  ps2_frame_rx #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk_i        (clock),
    .rst_ni       (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .scan_code_o  (scan_code),
    .scan_valid_o (scan_valid),
    .frame_error_o(frame_error)
  );

  always_comb begin
    keys_d = keys_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    // A dropped frame may have been a prefix; forget pending prefixes
    if (frame_error) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (scan_valid) begin
      if (scan_code == BREAK_PREFIX) begin
        brk_d = 1'b1;
      end else if (scan_code == EXT_PREFIX) begin
        ext_d = 1'b1;
      end else begin
        if (!ext_q) begin
          for (int n = 0; n < 4; n++) begin
            if (scan_code == KeyCodes[n]) begin
              keys_d[n] = ~brk_q;
            end
          end
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      keys_q <= '0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
    end
  end

  assign keys = keys_q;

endmodule
